// File: rtl/roadfighter_pkg.sv
// Shared types and constants for the Road Fighter object drawing and collision path.
package roadfighter_pkg;

    localparam logic [7:0] MASK_VALUE  = 8'h62;
    localparam int         NUM_AI_CARS = 4;

    typedef logic [7:0] color_t;

    typedef enum logic {ARMED, COOLDOWN} coll_state_t;

    // Every sprite drawer marks "no object here" with the same mask colour.
    function automatic logic is_opaque(input color_t c, input color_t mask);
        return c != mask;
    endfunction

endpackage

// File: rtl/objects_mux_collision_if.sv
// Pixel and game-event bundle between the sprite drawers, the collision block and game control.
interface objects_mux_collision_if
    import roadfighter_pkg::*;
#(
    parameter int NUM_AI = NUM_AI_CARS
) ();
    localparam int IDX_W = (NUM_AI > 1) ? $clog2(NUM_AI) : 1;

    logic                  frame_start;
    logic                  new_game;
    color_t                bg_color;
    color_t                player_color;
    color_t                bonus_color;
    color_t [NUM_AI-1:0]   ai_color;
    color_t                rgb_out;
    logic                  crash_pulse;
    logic                  bonus_pulse;
    logic [IDX_W-1:0]      crash_ai_idx;
    logic [7:0]            crash_count;
    logic                  immune;

    modport slave (
        input  frame_start, new_game, bg_color, player_color, bonus_color, ai_color,
        output rgb_out, crash_pulse, bonus_pulse, crash_ai_idx, crash_count, immune
    );

    modport master (
        output frame_start, new_game, bg_color, player_color, bonus_color, ai_color,
        input  rgb_out, crash_pulse, bonus_pulse, crash_ai_idx, crash_count, immune
    );

endinterface

// File: rtl/objects_mux_collision_pixel_priority_mux.sv
// Combinational layer select: player > bonus > ai[0..N-1] > background, mask colour is see-through.
module pixel_priority_mux
    import roadfighter_pkg::*;
#(
    parameter int     NUM_AI = NUM_AI_CARS,
    parameter color_t MASK   = roadfighter_pkg::MASK_VALUE
) (
    input  color_t              player_color,
    input  color_t              bonus_color,
    input  color_t [NUM_AI-1:0] ai_color,
    input  color_t              bg_color,
    output color_t              pixel_color,
    output logic                player_opaque,
    output logic                bonus_opaque,
    output logic [NUM_AI-1:0]   ai_opaque
);

    always_comb begin
        player_opaque = is_opaque(player_color, MASK);
        bonus_opaque  = is_opaque(bonus_color, MASK);
        ai_opaque     = '0;
        for (int i = 0; i < NUM_AI; i++) begin
            ai_opaque[i] = is_opaque(ai_color[i], MASK);
        end
    end

    // Paint from lowest priority upward so the last opaque layer written wins.
    always_comb begin
        pixel_color = bg_color;
        for (int i = NUM_AI - 1; i >= 0; i--) begin
            if (ai_opaque[i]) pixel_color = ai_color[i];
        end
        if (bonus_opaque)  pixel_color = bonus_color;
        if (player_opaque) pixel_color = player_color;
    end

endmodule

// File: rtl/objects_mux_collision.sv
// Final pixel colour register plus per-frame player collision detection and crash/bonus event FSM.
module objects_mux_collision #(
    parameter int         NUM_AI     = roadfighter_pkg::NUM_AI_CARS,
    parameter int         COOLDOWN   = 60,
    parameter logic [7:0] MASK_VALUE = roadfighter_pkg::MASK_VALUE
) (
    input  logic                  clk,
    input  logic                  resetN,
    objects_mux_collision_if.slave bus
);
    import roadfighter_pkg::*;

    localparam int IDX_W = (NUM_AI > 1) ? $clog2(NUM_AI) : 1;

    color_t              mux_color;
    logic                player_op;
    logic                bonus_op;
    logic [NUM_AI-1:0]   ai_op;

    logic                crash_ov;
    logic                bonus_ov;
    logic [IDX_W-1:0]    ov_idx;

    logic                crash_hit;
    logic                bonus_hit;
    logic [IDX_W-1:0]    ai_idx_lat;

    coll_state_t         state, state_next;
    logic [7:0]          cooldown_cnt, cooldown_next;
    logic                crash_pulse, crash_pulse_next;
    logic                bonus_pulse, bonus_pulse_next;
    logic [IDX_W-1:0]    crash_ai_idx, crash_ai_idx_next;
    logic [7:0]          crash_count, crash_count_next;
    color_t              rgb_q;

    pixel_priority_mux #(
        .NUM_AI (NUM_AI),
        .MASK   (MASK_VALUE)
    ) u_mux (
        .player_color  (bus.player_color),
        .bonus_color   (bus.bonus_color),
        .ai_color      (bus.ai_color),
        .bg_color      (bus.bg_color),
        .pixel_color   (mux_color),
        .player_opaque (player_op),
        .bonus_opaque  (bonus_op),
        .ai_opaque     (ai_op)
    );

    always_comb begin
        crash_ov = player_op && (|ai_op);
        bonus_ov = player_op && bonus_op;
        ov_idx   = '0;
        for (int i = NUM_AI - 1; i >= 0; i--) begin
            if (ai_op[i]) ov_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) rgb_q <= 8'h00;
        else         rgb_q <= mux_color;
    end

    // On frame_start the FSM consumes the old latches while this cycle's overlap seeds the new frame.
    always_ff @(posedge clk) begin
        if (!resetN || bus.new_game) begin
            crash_hit  <= 1'b0;
            bonus_hit  <= 1'b0;
            ai_idx_lat <= '0;
        end else if (bus.frame_start) begin
            crash_hit  <= crash_ov;
            bonus_hit  <= bonus_ov;
            ai_idx_lat <= ov_idx;
        end else begin
            if (crash_ov && !crash_hit) begin
                crash_hit  <= 1'b1;
                ai_idx_lat <= ov_idx;
            end
            if (bonus_ov) bonus_hit <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= roadfighter_pkg::ARMED;
            cooldown_cnt <= 8'd0;
            crash_pulse  <= 1'b0;
            bonus_pulse  <= 1'b0;
            crash_ai_idx <= '0;
            crash_count  <= 8'd0;
        end else begin
            state        <= state_next;
            cooldown_cnt <= cooldown_next;
            crash_pulse  <= crash_pulse_next;
            bonus_pulse  <= bonus_pulse_next;
            crash_ai_idx <= crash_ai_idx_next;
            crash_count  <= crash_count_next;
        end
    end

    always_comb begin
        state_next        = state;
        cooldown_next     = cooldown_cnt;
        crash_pulse_next  = 1'b0;
        bonus_pulse_next  = 1'b0;
        crash_ai_idx_next = crash_ai_idx;
        crash_count_next  = crash_count;

        if (bus.new_game) begin
            state_next       = roadfighter_pkg::ARMED;
            cooldown_next    = 8'd0;
            crash_count_next = 8'd0;
        end else if (bus.frame_start) begin
            case (state)
                roadfighter_pkg::ARMED: begin
                    // A crash swallows any bonus pickup from the same frame.
                    if (crash_hit) begin
                        crash_pulse_next  = 1'b1;
                        crash_ai_idx_next = ai_idx_lat;
                        if (crash_count != 8'hFF) crash_count_next = crash_count + 8'd1;
                        cooldown_next     = 8'(COOLDOWN);
                        state_next        = roadfighter_pkg::COOLDOWN;
                    end else if (bonus_hit) begin
                        bonus_pulse_next = 1'b1;
                    end
                end
                roadfighter_pkg::COOLDOWN: begin
                    if (bonus_hit) bonus_pulse_next = 1'b1;
                    if (cooldown_cnt <= 8'd1) begin
                        cooldown_next = 8'd0;
                        state_next    = roadfighter_pkg::ARMED;
                    end else begin
                        cooldown_next = cooldown_cnt - 8'd1;
                    end
                end
                default: state_next = roadfighter_pkg::ARMED;
            endcase
        end
    end

    assign bus.rgb_out      = rgb_q;
    assign bus.crash_pulse  = crash_pulse;
    assign bus.bonus_pulse  = bonus_pulse;
    assign bus.crash_ai_idx = crash_ai_idx;
    assign bus.crash_count  = crash_count;
    assign bus.immune       = (state == roadfighter_pkg::COOLDOWN);

endmodule

// File: tb/tb_objects_mux_collision.sv
// Bench for objects_mux_collision: mux vector table, directed collision sequences, random vs. frame model.
module tb_objects_mux_collision;
    import roadfighter_pkg::*;

    localparam int         NUM_AI = 4;
    localparam int         CD     = 3;
    localparam logic [7:0] MV     = 8'h62;

    typedef struct {
        logic [7:0]       pl;
        logic [7:0]       bo;
        logic [3:0][7:0]  ai;
        logic [7:0]       bg;
        logic [7:0]       exp_rgb;
    } mux_vec_t;

    logic clk = 1'b0;
    logic resetN;
    int   n_vectors = 0;
    int   n_miscompares = 0;

    always #5 clk = ~clk;

    objects_mux_collision_if #(.NUM_AI(NUM_AI)) bus ();

    objects_mux_collision #(
        .NUM_AI     (NUM_AI),
        .COOLDOWN   (CD),
        .MASK_VALUE (MV)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    // Reference model: frame-level bookkeeping of what was seen and how many immune frames remain.
    int  m_rgb = 0, m_crash_p = 0, m_bonus_p = 0, m_idx = 0, m_count = 0, m_frames_left = 0;
    bit  m_crash_seen = 0, m_bonus_seen = 0;
    int  m_first_ai = -1;

    function automatic logic [7:0] refPick(input logic [7:0] pl, input logic [7:0] bo,
                                           input logic [3:0][7:0] ai, input logic [7:0] bg);
        logic [7:0] layers[$];
        layers = {pl, bo, ai[0], ai[1], ai[2], ai[3]};
        foreach (layers[k]) if (layers[k] != MV) return layers[k];
        return bg;
    endfunction

    task automatic refModel(input logic rst_n, input logic fs, input logic ng, input logic [7:0] pl,
                            input logic [7:0] bo, input logic [3:0][7:0] ai, input logic [7:0] bg);
        bit crash_now, bonus_now;
        int first_now;
        if (!rst_n) begin
            m_rgb = 0; m_crash_p = 0; m_bonus_p = 0; m_idx = 0; m_count = 0; m_frames_left = 0;
            m_crash_seen = 0; m_bonus_seen = 0; m_first_ai = -1;
            return;
        end
        m_rgb     = refPick(pl, bo, ai, bg);
        first_now = -1;
        for (int i = 0; i < NUM_AI; i++) begin
            if (ai[i] != MV) begin first_now = i; break; end
        end
        crash_now = (pl != MV) && (first_now >= 0);
        bonus_now = (pl != MV) && (bo != MV);
        m_crash_p = 0;
        m_bonus_p = 0;
        if (ng) begin
            m_count = 0; m_frames_left = 0;
            m_crash_seen = 0; m_bonus_seen = 0; m_first_ai = -1;
        end else if (fs) begin
            if (m_frames_left == 0 && m_crash_seen) begin
                m_crash_p     = 1;
                m_idx         = m_first_ai;
                m_count       = (m_count >= 255) ? 255 : m_count + 1;
                m_frames_left = CD;
            end else begin
                if (m_bonus_seen) m_bonus_p = 1;
                if (m_frames_left > 0) m_frames_left--;
            end
            m_crash_seen = crash_now;
            m_bonus_seen = bonus_now;
            m_first_ai   = crash_now ? first_now : -1;
        end else begin
            if (crash_now && !m_crash_seen) m_first_ai = first_now;
            m_crash_seen = m_crash_seen || crash_now;
            m_bonus_seen = m_bonus_seen || bonus_now;
        end
    endtask

    task automatic expectEq(input string name, input int act, input int exp);
        n_vectors++;
        if (act != exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        expectEq("rgb_out",      int'(bus.rgb_out),      m_rgb);
        expectEq("crash_pulse",  int'(bus.crash_pulse),  m_crash_p);
        expectEq("bonus_pulse",  int'(bus.bonus_pulse),  m_bonus_p);
        expectEq("crash_ai_idx", int'(bus.crash_ai_idx), m_idx);
        expectEq("crash_count",  int'(bus.crash_count),  m_count);
        expectEq("immune",       int'(bus.immune),       (m_frames_left > 0) ? 1 : 0);
    endtask

    // Drive one clock of stimulus, advance the model across the edge and compare 1 ns later.
    task automatic applyStimulus(input logic rst_n, input logic fs, input logic ng, input logic [7:0] pl,
                                 input logic [7:0] bo, input logic [3:0][7:0] ai, input logic [7:0] bg);
        resetN           = rst_n;
        bus.frame_start  = fs;
        bus.new_game     = ng;
        bus.player_color = pl;
        bus.bonus_color  = bo;
        bus.ai_color     = ai;
        bus.bg_color     = bg;
        @(posedge clk);
        refModel(rst_n, fs, ng, pl, bo, ai, bg);
        #1;
        checkOutput();
    endtask

    function automatic logic [7:0] rndColor();
        return ($urandom_range(0, 1) == 0) ? MV : 8'($urandom_range(0, 255));
    endfunction

    logic [3:0][7:0] ai_none, ai_one, ai_zero, ai_rnd;
    mux_vec_t        tbl[8];
    int              exp_imm[4];
    int              exp_crash[4];

    initial begin
        ai_none = {MV, MV, MV, MV};
        ai_one  = {MV, MV, 8'hF8, MV};
        ai_zero = {MV, MV, MV, 8'hF8};

        tbl[0] = '{8'h62, 8'h62, {8'h62, 8'h1F, 8'h62, 8'h62}, 8'h24, 8'h1F};
        tbl[1] = '{8'hE4, 8'h62, {8'h62, 8'h1F, 8'h62, 8'h62}, 8'h24, 8'hE4};
        tbl[2] = '{8'h62, 8'h62, {8'h62, 8'h62, 8'h62, 8'h62}, 8'h24, 8'h24};
        tbl[3] = '{8'h62, 8'h3C, {8'h62, 8'h62, 8'h62, 8'h11}, 8'h24, 8'h3C};
        tbl[4] = '{8'h62, 8'h62, {8'h77, 8'h62, 8'h55, 8'h62}, 8'h24, 8'h55};
        tbl[5] = '{8'h62, 8'h62, {8'h77, 8'h62, 8'h62, 8'h62}, 8'h24, 8'h77};
        tbl[6] = '{8'h00, 8'h3C, {8'h77, 8'h62, 8'h55, 8'h11}, 8'h24, 8'h00};
        tbl[7] = '{8'h62, 8'h62, {8'h62, 8'h62, 8'h62, 8'h62}, 8'h62, 8'h62};

        // Reset values
        applyStimulus(0, 0, 0, 8'hE4, MV, ai_none, 8'h24);
        applyStimulus(0, 1, 0, 8'hE4, MV, ai_one, 8'h24);
        expectEq("reset_rgb", int'(bus.rgb_out), 0);
        expectEq("reset_count", int'(bus.crash_count), 0);
        expectEq("reset_immune", int'(bus.immune), 0);

        // Colour mux table
        for (int v = 0; v < 8; v++) begin
            applyStimulus(1, 0, 0, tbl[v].pl, tbl[v].bo, tbl[v].ai, tbl[v].bg);
            expectEq($sformatf("mux_tbl%0d", v), int'(bus.rgb_out), int'(tbl[v].exp_rgb));
        end

        // Single crash with ai[1]
        applyStimulus(1, 0, 1, MV, MV, ai_none, 8'h24);
        applyStimulus(1, 1, 0, MV, MV, ai_none, 8'h24);
        applyStimulus(1, 0, 0, 8'hE4, MV, ai_one, 8'h24);
        applyStimulus(1, 0, 0, MV, MV, ai_none, 8'h24);
        applyStimulus(1, 1, 0, MV, MV, ai_none, 8'h24);
        expectEq("t2_crash_pulse", int'(bus.crash_pulse), 1);
        expectEq("t2_crash_idx", int'(bus.crash_ai_idx), 1);
        expectEq("t2_crash_count", int'(bus.crash_count), 1);
        expectEq("t2_immune", int'(bus.immune), 1);
        applyStimulus(1, 0, 0, MV, MV, ai_none, 8'h24);
        expectEq("t2_pulse_width", int'(bus.crash_pulse), 0);

        // Cooldown of 3 frames with an overlap in every frame
        exp_imm   = '{1, 1, 0, 1};
        exp_crash = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 0, 0, 8'hE4, MV, ai_zero, 8'h24);
            applyStimulus(1, 1, 0, MV, MV, ai_none, 8'h24);
            expectEq($sformatf("t3_crash_f%0d", k + 1), int'(bus.crash_pulse), exp_crash[k]);
            expectEq($sformatf("t3_immune_f%0d", k + 1), int'(bus.immune), exp_imm[k]);
        end
        expectEq("t3_count", int'(bus.crash_count), 2);
        expectEq("t3_idx", int'(bus.crash_ai_idx), 0);

        // Crash and bonus in one frame, armed then immune
        applyStimulus(1, 0, 1, MV, MV, ai_none, 8'h24);
        applyStimulus(1, 0, 0, 8'hE4, 8'h3C, ai_zero, 8'h24);
        applyStimulus(1, 1, 0, MV, MV, ai_none, 8'h24);
        expectEq("t4_armed_crash", int'(bus.crash_pulse), 1);
        expectEq("t4_armed_bonus", int'(bus.bonus_pulse), 0);
        applyStimulus(1, 0, 0, 8'hE4, 8'h3C, ai_zero, 8'h24);
        applyStimulus(1, 1, 0, MV, MV, ai_none, 8'h24);
        expectEq("t4_cool_crash", int'(bus.crash_pulse), 0);
        expectEq("t4_cool_bonus", int'(bus.bonus_pulse), 1);

        // new_game wins over frame_start with a latched crash
        applyStimulus(1, 0, 1, MV, MV, ai_none, 8'h24);
        applyStimulus(1, 0, 0, 8'hE4, MV, ai_one, 8'h24);
        applyStimulus(1, 1, 1, MV, MV, ai_none, 8'h24);
        expectEq("t5_no_pulse", int'(bus.crash_pulse), 0);
        expectEq("t5_count", int'(bus.crash_count), 0);
        expectEq("t5_armed", int'(bus.immune), 0);
        applyStimulus(1, 1, 0, MV, MV, ai_none, 8'h24);
        expectEq("t5_latch_cleared", int'(bus.crash_pulse), 0);

        // Saturate crash_count with a permanent overlap, then reset mid-cooldown
        applyStimulus(1, 0, 1, 8'hE4, MV, ai_one, 8'h24);
        for (int f = 0; f < 1030; f++) begin
            applyStimulus(1, 0, 0, 8'hE4, MV, ai_one, 8'h24);
            applyStimulus(1, 1, 0, 8'hE4, MV, ai_one, 8'h24);
        end
        expectEq("t6_saturated", int'(bus.crash_count), 255);
        expectEq("t6_in_cooldown", int'(bus.immune), 1);
        applyStimulus(0, 1, 0, 8'hE4, MV, ai_one, 8'h24);
        expectEq("t6_reset_rgb", int'(bus.rgb_out), 0);
        expectEq("t6_reset_count", int'(bus.crash_count), 0);
        expectEq("t6_reset_immune", int'(bus.immune), 0);
        expectEq("t6_reset_idx", int'(bus.crash_ai_idx), 0);

        // Randomized traffic against the frame model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_AI; i++) ai_rnd[i] = rndColor();
            applyStimulus(($urandom_range(0, 499) != 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 149) == 0),
                          rndColor(), rndColor(), ai_rnd, 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
